// File: rtl/pwm_multi_channel.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_multi_channel
//  Description : Multi-channel PWM generator with shared prescaler and period
//                counter, double-buffered duty registers and registered outputs.
//  Revision    : 1.0 - initial release
// ============================================================================

module pwm_multi_channel #(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 8,
    parameter int PRE_W  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [$clog2(NUM_CH+4)-1:0] wr_addr,
    input  logic [CNT_W-1:0]            wr_data,
    output logic [NUM_CH-1:0]           pwm_out,
    output logic                        period_done
);

    localparam int c_ADDR_W = $clog2(NUM_CH + 4);

    localparam logic [c_ADDR_W-1:0] c_ADDR_CTRL   = c_ADDR_W'(NUM_CH);
    localparam logic [c_ADDR_W-1:0] c_ADDR_PRESC  = c_ADDR_W'(NUM_CH + 1);
    localparam logic [c_ADDR_W-1:0] c_ADDR_PERIOD = c_ADDR_W'(NUM_CH + 2);
    localparam logic [c_ADDR_W-1:0] c_ADDR_CHEN   = c_ADDR_W'(NUM_CH + 3);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0]  r_shadow_q  [NUM_CH];
    logic [CNT_W-1:0]  w_shadow_d  [NUM_CH];
    logic [CNT_W-1:0]  r_duty_q    [NUM_CH];
    logic [CNT_W-1:0]  w_duty_d    [NUM_CH];

    logic [1:0]        r_ctrl_q;
    logic [1:0]        w_ctrl_d;
    logic [PRE_W-1:0]  r_prescale_q;
    logic [PRE_W-1:0]  w_prescale_d;
    logic [CNT_W-1:0]  r_period_q;
    logic [CNT_W-1:0]  w_period_d;
    logic [NUM_CH-1:0] r_ch_en_q;
    logic [NUM_CH-1:0] w_ch_en_d;

    logic [PRE_W-1:0]  r_pre_cnt_q;
    logic [PRE_W-1:0]  w_pre_cnt_d;
    logic [CNT_W-1:0]  r_cnt_q;
    logic [CNT_W-1:0]  w_cnt_d;

    logic [NUM_CH-1:0] r_pwm_out_q;
    logic [NUM_CH-1:0] w_pwm_out_d;
    logic              r_period_done_q;
    logic              w_period_done_d;

    logic              w_enable;
    logic              w_invert;
    logic              w_tick;
    logic              w_wrap;

    assign w_enable = r_ctrl_q[0];
    assign w_invert = r_ctrl_q[1];

    // ------------------------------------------------------------------------
    // Register file write decode
    // ------------------------------------------------------------------------
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            w_shadow_d[ch] = r_shadow_q[ch];
        end
        w_ctrl_d     = r_ctrl_q;
        w_prescale_d = r_prescale_q;
        w_period_d   = r_period_q;
        w_ch_en_d    = r_ch_en_q;

        // Addresses past the channel-enable register match nothing and fall through.
        if (wr_en) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (wr_addr == c_ADDR_W'(ch)) begin
                    w_shadow_d[ch] = wr_data;
                end
            end
            if (wr_addr == c_ADDR_CTRL) begin
                w_ctrl_d = wr_data[1:0];
            end
            if (wr_addr == c_ADDR_PRESC) begin
                w_prescale_d = wr_data[PRE_W-1:0];
            end
            if (wr_addr == c_ADDR_PERIOD) begin
                w_period_d = wr_data;
            end
            if (wr_addr == c_ADDR_CHEN) begin
                w_ch_en_d = wr_data[NUM_CH-1:0];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Prescaler and period counter
    // ------------------------------------------------------------------------
    assign w_tick = w_enable && (r_pre_cnt_q == r_prescale_q);
    // ">=" lets a shrunken period wrap on the very next tick.
    assign w_wrap = w_tick && (r_cnt_q >= r_period_q);

    always_comb begin
        w_pre_cnt_d = r_pre_cnt_q;
        w_cnt_d     = r_cnt_q;
        if (!w_enable) begin
            w_pre_cnt_d = '0;
            w_cnt_d     = '0;
        end else if (w_tick) begin
            w_pre_cnt_d = '0;
            if (w_wrap) begin
                w_cnt_d = '0;
            end else begin
                w_cnt_d = r_cnt_q + CNT_W'(1);
            end
        end else begin
            w_pre_cnt_d = r_pre_cnt_q + PRE_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Active duty: reloads from the pre-write shadow at wrap, tracks it while idle
    // ------------------------------------------------------------------------
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            w_duty_d[ch] = r_duty_q[ch];
            if (!w_enable || w_wrap) begin
                w_duty_d[ch] = r_shadow_q[ch];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output compare
    // ------------------------------------------------------------------------
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (w_enable && r_ch_en_q[ch]) begin
                w_pwm_out_d[ch] = (r_cnt_q < r_duty_q[ch]) ^ w_invert;
            end else begin
                w_pwm_out_d[ch] = w_invert;
            end
        end
        // A wrap coinciding with a disabling ctrl write is not reported.
        w_period_done_d = w_wrap && w_ctrl_d[0];
    end

    // ------------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_shadow_q[ch] <= '0;
                r_duty_q[ch]   <= '0;
            end
            r_ctrl_q        <= '0;
            r_prescale_q    <= '0;
            r_period_q      <= '1;
            r_ch_en_q       <= '0;
            r_pre_cnt_q     <= '0;
            r_cnt_q         <= '0;
            r_pwm_out_q     <= '0;
            r_period_done_q <= 1'b0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_shadow_q[ch] <= w_shadow_d[ch];
                r_duty_q[ch]   <= w_duty_d[ch];
            end
            r_ctrl_q        <= w_ctrl_d;
            r_prescale_q    <= w_prescale_d;
            r_period_q      <= w_period_d;
            r_ch_en_q       <= w_ch_en_d;
            r_pre_cnt_q     <= w_pre_cnt_d;
            r_cnt_q         <= w_cnt_d;
            r_pwm_out_q     <= w_pwm_out_d;
            r_period_done_q <= w_period_done_d;
        end
    end

    assign pwm_out     = r_pwm_out_q;
    assign period_done = r_period_done_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_multi_channel.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_multi_channel
//  Description : Directed and randomized checks of pwm_multi_channel against
//                a cycle-level behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_pwm_multi_channel;

    localparam int NUM_CH = 8;
    localparam int CNT_W  = 8;
    localparam int PRE_W  = 4;
    localparam int AW     = $clog2(NUM_CH + 4);

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [CNT_W-1:0]  wr_data;
    logic [NUM_CH-1:0] pwm_out;
    logic              period_done;

    pwm_multi_channel #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .pwm_out     (pwm_out),
        .period_done (period_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state (plain integers)
    int m_shadow [NUM_CH];
    int m_active [NUM_CH];
    int m_enable, m_invert, m_prescale, m_period, m_chen;
    int m_pre, m_cnt;
    logic [NUM_CH-1:0] e_pwm;
    logic              e_done;

    // Observed tallies for waveform-level checks
    int t_hi [NUM_CH];
    int t_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_shadow[c] = 0;
            m_active[c] = 0;
        end
        m_enable = 0; m_invert = 0; m_prescale = 0;
        m_period = (1 << CNT_W) - 1;
        m_chen = 0; m_pre = 0; m_cnt = 0;
        e_pwm = '0; e_done = 1'b0;
    endtask

    // One clock edge of the model: outputs from the pre-edge state, then update.
    task automatic model_edge();
        bit tick, wrap;
        if (rst) begin
            model_reset();
            return;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (m_enable != 0 && ((m_chen >> c) & 1) != 0)
                e_pwm[c] = ((m_cnt < m_active[c]) ? 1'b1 : 1'b0) ^ m_invert[0];
            else
                e_pwm[c] = m_invert[0];
        end
        tick = (m_enable != 0) && (m_pre == m_prescale);
        wrap = tick && (m_cnt >= m_period);
        for (int c = 0; c < NUM_CH; c++)
            if (m_enable == 0 || wrap) m_active[c] = m_shadow[c];
        if (m_enable == 0) begin
            m_pre = 0;
            m_cnt = 0;
        end else if (tick) begin
            m_pre = 0;
            m_cnt = wrap ? 0 : m_cnt + 1;
        end else begin
            m_pre = (m_pre + 1) % (1 << PRE_W);
        end
        if (wr_en) begin
            if (int'(wr_addr) < NUM_CH) m_shadow[wr_addr] = int'(wr_data);
            else if (int'(wr_addr) == NUM_CH) begin
                m_enable = int'(wr_data[0]);
                m_invert = int'(wr_data[1]);
            end
            else if (int'(wr_addr) == NUM_CH + 1) m_prescale = int'(wr_data) % (1 << PRE_W);
            else if (int'(wr_addr) == NUM_CH + 2) m_period = int'(wr_data);
            else if (int'(wr_addr) == NUM_CH + 3) m_chen = int'(wr_data) % (1 << NUM_CH);
        end
        e_done = wrap && (m_enable != 0);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("pwm_out", 32'(pwm_out), 32'(e_pwm));
        chk("period_done", 32'(period_done), 32'(e_done));
        for (int c = 0; c < NUM_CH; c++) t_hi[c] += int'(pwm_out[c]);
        t_done += int'(period_done);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic clear_tally();
        for (int c = 0; c < NUM_CH; c++) t_hi[c] = 0;
        t_done = 0;
    endtask

    task automatic wr(input int addr, input int data);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = CNT_W'(data);
        cyc();
        wr_en   = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            cyc();
            n++;
        end while (period_done !== 1'b1 && n < 300);
        chk("wait_done_timeout", 32'(period_done), 32'd1);
    endtask

    initial begin
        int hi_sum;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        model_reset();
        clear_tally();

        // Reset state and idle
        cyc();
        chk("reset_pwm", 32'(pwm_out), 32'd0);
        chk("reset_done", 32'(period_done), 32'd0);
        rst = 1'b0;
        clear_tally();
        run(10);
        chk("idle_pwm_high_cycles", 32'(t_hi[0] + t_hi[7]), 32'd0);
        chk("idle_done_count", 32'(t_done), 32'd0);

        // period=9, prescale=0, duty0=3: 3 high of 10, one done per 10
        wr(NUM_CH + 2, 9);
        wr(NUM_CH + 1, 0);
        wr(0, 3);
        wr(NUM_CH + 3, 8'h01);
        wr(NUM_CH, 8'h01);
        run(2);
        clear_tally(); run(10);
        chk("basic_ch0_high", 32'(t_hi[0]), 32'd3);
        chk("basic_done", 32'(t_done), 32'd1);
        clear_tally(); run(10);
        chk("basic_ch0_high_2", 32'(t_hi[0]), 32'd3);
        chk("basic_done_2", 32'(t_done), 32'd1);

        // prescale=1, period=3, duty1=2: 4 high of 8
        wr(NUM_CH + 1, 1);
        wr(NUM_CH + 2, 3);
        wr(1, 2);
        wr(NUM_CH + 3, 8'h03);
        wait_done(); wait_done();
        clear_tally(); run(8);
        chk("presc_ch1_high", 32'(t_hi[1]), 32'd4);
        chk("presc_ch0_high", 32'(t_hi[0]), 32'd6);
        chk("presc_done", 32'(t_done), 32'd1);

        // Mid-period duty write applies at the next period
        wr(NUM_CH + 1, 0);
        wr(NUM_CH + 2, 9);
        wait_done(); wait_done();
        clear_tally();
        run(3);
        wr(0, 7);
        run(6);
        chk("shadow_cur_period", 32'(t_hi[0]), 32'd3);
        chk("shadow_cur_done", 32'(t_done), 32'd1);
        clear_tally(); run(10);
        chk("shadow_next_period", 32'(t_hi[0]), 32'd7);

        // duty 0 / duty 255, then inversion with a disabled channel
        wr(2, 0);
        wr(3, 255);
        wr(NUM_CH + 3, 8'h0F);
        wait_done(); wait_done();
        clear_tally(); run(10);
        chk("duty0_low", 32'(t_hi[2]), 32'd0);
        chk("duty255_high", 32'(t_hi[3]), 32'd10);
        wr(NUM_CH, 8'h03);
        run(2);
        clear_tally(); run(10);
        chk("inv_disabled_idle_high", 32'(t_hi[4]), 32'd10);
        chk("inv_duty0", 32'(t_hi[2]), 32'd10);
        chk("inv_duty255", 32'(t_hi[3]), 32'd0);
        chk("inv_ch0", 32'(t_hi[0]), 32'd3);

        // Reset mid-period with a simultaneous write, then out-of-range write
        run(4);
        rst = 1'b1; wr_en = 1'b1; wr_addr = AW'(0); wr_data = 8'h55;
        cyc();
        rst = 1'b0; wr_en = 1'b0;
        chk("midrst_pwm", 32'(pwm_out), 32'd0);
        chk("midrst_done", 32'(period_done), 32'd0);
        wr(NUM_CH + 4, 8'hFF);
        wr(NUM_CH + 2, 9);
        wr(NUM_CH + 3, 8'hFF);
        wr(NUM_CH, 8'h01);
        clear_tally(); run(25);
        hi_sum = 0;
        for (int c = 0; c < NUM_CH; c++) hi_sum += t_hi[c];
        chk("oor_no_effect_high", 32'(hi_sum), 32'd0);
        chk("oor_done_count", 32'(t_done), 32'd2);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            int a;
            rst   = ($urandom_range(0, 149) == 0);
            wr_en = ($urandom_range(0, 3) == 0);
            a = int'($urandom_range(0, 15));
            wr_addr = AW'(a);
            if (a == NUM_CH + 2)      wr_data = CNT_W'($urandom_range(0, 20));
            else if (a == NUM_CH + 1) wr_data = CNT_W'($urandom_range(0, 3) | ($urandom_range(0, 15) << 4));
            else                      wr_data = CNT_W'($urandom);
            cyc();
        end
        rst = 1'b0; wr_en = 1'b0;
        run(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
